guineveer_rst_seq: RTL and testbench
====================================

GUINEVEER_RST_SEQ -- requirements
Module: guineveer_rst_seq

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 3: cycles all resets stay asserted after entering HOLD; legal range 1..255.
REQ-002 SHALL have parameter STAGE_GAP, default 4: cycles between successive reset releases; legal range 1..255.
REQ-003 SHALL have parameter I3C_TIMEOUT, default 16: WAIT_I3C samples of i3c_clk_ok_i before giving up; legal range 1..255.
REQ-004 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port i3c_clk_ok_i, input, 1 bit: level, high when the I3C clock is stable.
REQ-007 SHALL have port sw_rst_req_i, input, 1 bit: software re-reset request; acted on only in RUN.
REQ-008 SHALL have port sys_rst_no, output, 1 bit: active-low system/fabric reset.
REQ-009 SHALL have port i3c_rst_no, output, 1 bit: active-low I3C controller reset.
REQ-010 SHALL have port cpu_rst_no, output, 1 bit: active-low CPU reset.
REQ-011 SHALL have port done_o, output, 1 bit: high while in RUN.
REQ-012 SHALL have port i3c_timeout_o, output, 1 bit: sticky flag, set when the I3C clock did not come up in time.
REQ-013 SHALL have port state_o, output, 3 bits: encoded FSM state.

Function
REQ-014 SHALL register all outputs; no combinational path from input to output.
REQ-015 SHALL use state encoding HOLD=0, GAP1=1, WAIT_I3C=2, GAP2=3, RUN=4, UNW_I3C=5, UNW_SYS=6; value 7 SHALL return to HOLD on the next edge.
REQ-016 SHALL use one 8-bit cycle counter, cleared on every state transition; it SHALL saturate and never wrap.
REQ-017 SHALL, in HOLD, hold all three resets asserted; at the HOLD_CYCLES-th edge in HOLD it SHALL set sys_rst_no=1 and go to GAP1.
REQ-018 SHALL, in GAP1, go to WAIT_I3C at the STAGE_GAP-th edge.
REQ-019 SHALL, in WAIT_I3C, on the first edge that samples i3c_clk_ok_i=1, set i3c_rst_no=1 and go to GAP2.
REQ-020 SHALL, in WAIT_I3C, if the I3C_TIMEOUT-th sample is still 0, set i3c_timeout_o=1, keep i3c_rst_no=0 and go to GAP2.
REQ-021 SHALL, in GAP2, at the STAGE_GAP-th edge, set cpu_rst_no=1 and done_o=1 and go to RUN.
REQ-022 SHALL, in RUN, on an edge sampling sw_rst_req_i=1, set cpu_rst_no=0 and done_o=0 and go to UNW_I3C.
REQ-023 SHALL, in UNW_I3C, set i3c_rst_no=0 on the next edge and go to UNW_SYS.
REQ-024 SHALL, in UNW_SYS, set sys_rst_no=0 on the next edge and go to HOLD; the full sequence then repeats.
REQ-025 SHALL ignore sw_rst_req_i outside RUN; requests SHALL NOT be queued.
REQ-026 SHALL never have cpu_rst_no=1 while sys_rst_no=0.
REQ-027 SHALL never have i3c_rst_no=1 while sys_rst_no=0.
REQ-028 SHALL NOT clear i3c_timeout_o on a software re-reset; only rst_i clears it.

Reset
REQ-029 SHALL, while rst_i=1, asynchronously force state=HOLD, counter=0, sys_rst_no=0, i3c_rst_no=0, cpu_rst_no=0, done_o=0, i3c_timeout_o=0.
REQ-030 SHALL, if rst_i is asserted mid-sequence or in RUN, drop all outputs immediately, without the UNW ordering.
REQ-031 SHALL start counting at the first rising edge after rst_i is released.

Configuration
REQ-032 SHALL, with macro GUINEVEER_RST_SEQ_DBG_HOLD_EN defined, add input dbg_cpu_hold_i (1 bit); while it is 1, GAP2 SHALL NOT leave for RUN.
REQ-033 SHALL stall GAP2 with its counter saturated; release SHALL occur on the first edge with dbg_cpu_hold_i=0 and the count complete.
REQ-034 SHALL, without the macro, omit the port and behave as if dbg_cpu_hold_i=0.

Verification
REQ-035 SHALL cover the nominal sequence: defaults, i3c_clk_ok_i=1, edge 1 = first after rst_i falls -> sys_rst_no rises at edge 3, i3c_rst_no at 8, cpu_rst_no and done_o at 12.
REQ-036 SHALL cover timeout: i3c_clk_ok_i=0 -> i3c_timeout_o rises at edge 23, cpu_rst_no at edge 27, i3c_rst_no stays 0.
REQ-037 SHALL cover software re-reset: sw_rst_req_i sampled at RUN edge N -> cpu_rst_no falls at N, i3c_rst_no at N+1, sys_rst_no at N+2; sys_rst_no rises again at N+5.
REQ-038 SHALL cover reset mid-operation: rst_i pulsed while in GAP2 -> all outputs 0 with no clock edge; the sequence restarts per REQ-035.
REQ-039 SHALL cover the debug hold: macro defined, dbg_cpu_hold_i=1 until edge 20 -> cpu_rst_no rises at the first edge with the hold low.
REQ-040 SHALL cover ignored requests: sw_rst_req_i held 1 during HOLD..GAP2 -> no effect, and the unwind starts at the first RUN edge.

Source files
------------

// File: rtl/guineveer_rst_seq.sv
// Staged reset sequencer: releases system, I3C and CPU resets in order and unwinds them on a software request.
// Optional debug CPU hold is enabled by defining GUINEVEER_RST_SEQ_DBG_HOLD_EN.
module guineveer_rst_seq #(
    parameter int unsigned HOLD_CYCLES = 3,
    parameter int unsigned STAGE_GAP   = 4,
    parameter int unsigned I3C_TIMEOUT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       i3c_clk_ok_i,
    input  logic       sw_rst_req_i,
`ifdef GUINEVEER_RST_SEQ_DBG_HOLD_EN
    input  logic       dbg_cpu_hold_i,
`endif
    output logic       sys_rst_no,
    output logic       i3c_rst_no,
    output logic       cpu_rst_no,
    output logic       done_o,
    output logic       i3c_timeout_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        HOLD     = 3'd0,
        GAP1     = 3'd1,
        WAIT_I3C = 3'd2,
        GAP2     = 3'd3,
        RUN      = 3'd4,
        UNW_I3C  = 3'd5,
        UNW_SYS  = 3'd6
    } state_t;

    // Counter value seen on the edge that completes each stage.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LAST  = 8'(STAGE_GAP - 1);
    localparam logic [7:0] TO_LAST   = 8'(I3C_TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [7:0] cnt_inc;
    logic       dbg_hold;

`ifdef GUINEVEER_RST_SEQ_DBG_HOLD_EN
    assign dbg_hold = dbg_cpu_hold_i;
`else
    assign dbg_hold = 1'b0;
`endif

    always_comb begin
        cnt_inc = (cnt == '1) ? cnt : cnt + 8'd1;
    end

    assign state_o = state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= HOLD;
            cnt           <= '0;
            sys_rst_no    <= 1'b0;
            i3c_rst_no    <= 1'b0;
            cpu_rst_no    <= 1'b0;
            done_o        <= 1'b0;
            i3c_timeout_o <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    sys_rst_no <= 1'b0;
                    i3c_rst_no <= 1'b0;
                    cpu_rst_no <= 1'b0;
                    done_o     <= 1'b0;
                    if (cnt == HOLD_LAST) begin
                        sys_rst_no <= 1'b1;
                        state      <= GAP1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                GAP1: begin
                    if (cnt == GAP_LAST) begin
                        state <= WAIT_I3C;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                WAIT_I3C: begin
                    if (i3c_clk_ok_i) begin
                        i3c_rst_no <= 1'b1;
                        state      <= GAP2;
                        cnt        <= '0;
                    end else if (cnt == TO_LAST) begin
                        i3c_timeout_o <= 1'b1;
                        state         <= GAP2;
                        cnt           <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                GAP2: begin
                    // A debug hold keeps counting up to saturation, so release needs only the hold to drop.
                    if (cnt >= GAP_LAST && !dbg_hold) begin
                        cpu_rst_no <= 1'b1;
                        done_o     <= 1'b1;
                        state      <= RUN;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                RUN: begin
                    if (sw_rst_req_i) begin
                        cpu_rst_no <= 1'b0;
                        done_o     <= 1'b0;
                        state      <= UNW_I3C;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                UNW_I3C: begin
                    i3c_rst_no <= 1'b0;
                    state      <= UNW_SYS;
                    cnt        <= '0;
                end
                UNW_SYS: begin
                    sys_rst_no <= 1'b0;
                    state      <= HOLD;
                    cnt        <= '0;
                end
                default: begin
                    sys_rst_no <= 1'b0;
                    i3c_rst_no <= 1'b0;
                    cpu_rst_no <= 1'b0;
                    done_o     <= 1'b0;
                    state      <= HOLD;
                    cnt        <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_guineveer_rst_seq.sv
// Directed bench for guineveer_rst_seq: nominal table plus timeout, re-reset, mid-run reset and ignored-request sequences.
// The debug-hold sequence is compiled in when GUINEVEER_RST_SEQ_DBG_HOLD_EN is defined.
module tb_guineveer_rst_seq;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       i3c_clk_ok_i = 1'b0;
    logic       sw_rst_req_i = 1'b0;
`ifdef GUINEVEER_RST_SEQ_DBG_HOLD_EN
    logic       dbg_cpu_hold_i = 1'b0;
`endif
    logic       sys_rst_no, i3c_rst_no, cpu_rst_no, done_o, i3c_timeout_o;
    logic [2:0] state_o;

    int unsigned errors = 0;
    int unsigned checks = 0;

    guineveer_rst_seq #(.HOLD_CYCLES(3), .STAGE_GAP(4), .I3C_TIMEOUT(16)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .i3c_clk_ok_i  (i3c_clk_ok_i),
        .sw_rst_req_i  (sw_rst_req_i),
`ifdef GUINEVEER_RST_SEQ_DBG_HOLD_EN
        .dbg_cpu_hold_i(dbg_cpu_hold_i),
`endif
        .sys_rst_no    (sys_rst_no),
        .i3c_rst_no    (i3c_rst_no),
        .cpu_rst_no    (cpu_rst_no),
        .done_o        (done_o),
        .i3c_timeout_o (i3c_timeout_o),
        .state_o       (state_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       ok;
        logic       req;
        logic [7:0] exp;
    } vec_t;

    vec_t nom [14];

    // Packed as {sys, i3c, cpu, done, timeout, state[2:0]}.
    function automatic logic [7:0] ev(input logic sys, input logic i3c, input logic cpu,
                                      input logic dn, input logic to, input logic [2:0] st);
        return {sys, i3c, cpu, dn, to, st};
    endfunction

    function automatic logic [7:0] outs();
        return {sys_rst_no, i3c_rst_no, cpu_rst_no, done_o, i3c_timeout_o, state_o};
    endfunction

    task automatic check(input string name, input logic [7:0] exp);
        logic [7:0] got;
        got = outs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {sys,i3c,cpu,done,to,st}=%b required %b", name, got, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Async reset pulse between edges; outputs must clear with no clock edge. Edge 1 is the next posedge.
    task automatic pulse_reset(input string name);
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1 check(name, 8'h00);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic run_nominal(input string tag);
        for (int i = 0; i < 14; i++) begin
            i3c_clk_ok_i = nom[i].ok;
            sw_rst_req_i = nom[i].req;
            step(1);
            check($sformatf("%s_edge%0d", tag, i + 1), nom[i].exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 14; i++) begin
            nom[i].ok  = 1'b1;
            nom[i].req = 1'b0;
            if (i < 2)       nom[i].exp = ev(0, 0, 0, 0, 0, 3'd0);
            else if (i < 6)  nom[i].exp = ev(1, 0, 0, 0, 0, 3'd1);
            else if (i == 6) nom[i].exp = ev(1, 0, 0, 0, 0, 3'd2);
            else if (i < 11) nom[i].exp = ev(1, 1, 0, 0, 0, 3'd3);
            else             nom[i].exp = ev(1, 1, 1, 1, 0, 3'd4);
        end

        // Power-on reset, then the nominal table.
        #12 check("reset_state", 8'h00);
        @(negedge clk_i);
        rst_i = 1'b0;
        run_nominal("nominal");

        // Software re-reset sampled at edge N=15.
        sw_rst_req_i = 1'b1;
        step(1);
        sw_rst_req_i = 1'b0;
        check("swrst_N_cpu_fall", ev(1, 1, 0, 0, 0, 3'd5));
        step(1);
        check("swrst_N1_i3c_fall", ev(1, 0, 0, 0, 0, 3'd6));
        step(1);
        check("swrst_N2_sys_fall", ev(0, 0, 0, 0, 0, 3'd0));
        step(2);
        check("swrst_N4_hold", ev(0, 0, 0, 0, 0, 3'd0));
        step(1);
        check("swrst_N5_sys_rise", ev(1, 0, 0, 0, 0, 3'd1));

        // I3C clock never comes up.
        i3c_clk_ok_i = 1'b0;
        pulse_reset("reset_before_timeout");
        step(22);
        check("timeout_edge22", ev(1, 0, 0, 0, 0, 3'd2));
        step(1);
        check("timeout_edge23", ev(1, 0, 0, 0, 1, 3'd3));
        step(3);
        check("timeout_edge26", ev(1, 0, 0, 0, 1, 3'd3));
        step(1);
        check("timeout_edge27", ev(1, 0, 1, 1, 1, 3'd4));
        sw_rst_req_i = 1'b1;
        step(1);
        sw_rst_req_i = 1'b0;
        step(2);
        check("timeout_sticky_swrst", ev(0, 0, 0, 0, 1, 3'd0));

        // Reset pulsed while in GAP2, then the full sequence again.
        i3c_clk_ok_i = 1'b1;
        pulse_reset("reset_clears_timeout");
        step(10);
        check("midop_gap2", ev(1, 1, 0, 0, 0, 3'd3));
        pulse_reset("midop_async_clear");
        run_nominal("restart");

        // Request held from reset release through GAP2 must not act before RUN.
        pulse_reset("reset_before_ignored");
        sw_rst_req_i = 1'b1;
        step(11);
        check("ignored_edge11", ev(1, 1, 0, 0, 0, 3'd3));
        step(1);
        check("ignored_edge12_run", ev(1, 1, 1, 1, 0, 3'd4));
        step(1);
        check("ignored_edge13_unwind", ev(1, 1, 0, 0, 0, 3'd5));
        sw_rst_req_i = 1'b0;
        step(1);
        check("ignored_edge14", ev(1, 0, 0, 0, 0, 3'd6));

`ifdef GUINEVEER_RST_SEQ_DBG_HOLD_EN
        // Debug hold high through edge 20; release at edge 21.
        dbg_cpu_hold_i = 1'b1;
        pulse_reset("reset_before_dbg");
        step(12);
        check("dbg_edge12_held", ev(1, 1, 0, 0, 0, 3'd3));
        step(8);
        check("dbg_edge20_held", ev(1, 1, 0, 0, 0, 3'd3));
        dbg_cpu_hold_i = 1'b0;
        step(1);
        check("dbg_edge21_release", ev(1, 1, 1, 1, 0, 3'd4));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
